// File: rtl/tbuf_drain.sv
// tbuf_drain
//   Drain side of the per-thread tbuf address tracker. Store addresses are
//   queued per thread (two independent in-order queues). One address at a time
//   is issued to the downstream write port over a valid/ready handshake. When
//   both threads have work, the output arbiter alternates between them.
//   An exception flushes every pending address of the excepting thread.
//
// Ports
//   i_clk            clock, all state updates on posedge
//   i_rst            synchronous reset, active-low
//   i_except         exception flush request
//   i_except_thread  thread to flush
//   i_in_addr        address to enqueue
//   i_in_thread      thread of i_in_addr
//   i_in_en          enqueue strobe
//   o_free[t]        queue t has at least one free slot
//   o_out_valid      output register holds an address
//   o_out_addr       address being issued
//   o_out_thread     thread of o_out_addr
//   i_out_ready      downstream accepts the output this cycle
//   o_ovf            sticky flag: an enqueue hit a full queue

module tbuf_drain #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_except,
  input  logic             i_except_thread,
  input  logic [WIDTH-1:0] i_in_addr,
  input  logic             i_in_thread,
  input  logic             i_in_en,
  output logic [1:0]       o_free,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_addr,
  output logic             o_out_thread,
  input  logic             i_out_ready,
  output logic             o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem   [2][DEPTH];
  logic [PW-1:0]    r_rdPtr [2];
  logic [PW-1:0]    r_wrPtr [2];
  logic [CW-1:0]    r_count [2];
  logic             r_rr;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outAddr;
  logic             r_outThread;
  logic             r_ovf;

  logic [1:0]       w_flush;
  logic [1:0]       w_avail;
  logic [1:0]       w_enq;
  logic [1:0]       w_deq;
  logic             w_loadSlot;
  logic             w_pick;
  logic [WIDTH-1:0] w_head;
  logic             w_inFull;
  logic             w_inFlushed;
  logic             w_ovfSet;

  // A flushed thread is treated as empty for this cycle's load, and its
  // same-cycle enqueue is discarded without raising ovf. The full check uses
  // the start-of-cycle count, so a slot freed by this cycle's load is not
  // reusable until the next cycle.
  always_comb begin
    w_flush     = 2'b00;
    w_flush[0]  = i_except & ~i_except_thread;
    w_flush[1]  = i_except & i_except_thread;
    w_avail[0]  = (r_count[0] != '0) && !w_flush[0];
    w_avail[1]  = (r_count[1] != '0) && !w_flush[1];
    w_loadSlot  = !r_outValid || i_out_ready;
    // Both threads waiting: grant the one not granted last time.
    w_pick      = (w_avail == 2'b11) ? ~r_rr : w_avail[1];
    w_head      = r_mem[w_pick][r_rdPtr[w_pick]];
    w_deq[0]    = w_loadSlot && w_avail[0] && !w_pick;
    w_deq[1]    = w_loadSlot && w_avail[1] && w_pick;
    w_inFull    = (r_count[i_in_thread] == CW'(DEPTH));
    w_inFlushed = w_flush[i_in_thread];
    w_enq[0]    = i_in_en && !i_in_thread && !w_inFlushed && !w_inFull;
    w_enq[1]    = i_in_en && i_in_thread && !w_inFlushed && !w_inFull;
    w_ovfSet    = i_in_en && !w_inFlushed && w_inFull;
  end

  // Pointer and occupancy bookkeeping per thread; a flush wins over any
  // same-cycle enqueue or dequeue of that thread.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int t = 0; t < 2; t++) begin
        r_rdPtr[t] <= '0;
        r_wrPtr[t] <= '0;
        r_count[t] <= '0;
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        if (w_flush[t]) begin
          r_rdPtr[t] <= '0;
          r_wrPtr[t] <= '0;
          r_count[t] <= '0;
        end else begin
          if (w_enq[t]) r_wrPtr[t] <= r_wrPtr[t] + PW'(1);
          if (w_deq[t]) r_rdPtr[t] <= r_rdPtr[t] + PW'(1);
          r_count[t] <= r_count[t] + CW'(w_enq[t]) - CW'(w_deq[t]);
        end
      end
    end
  end

  // Queue storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    for (int t = 0; t < 2; t++) begin
      if (w_enq[t]) r_mem[t][r_wrPtr[t]] <= i_in_addr;
    end
  end

  // Output register. It reloads whenever it is empty or being accepted.
  // Otherwise it holds, unless its entry belongs to the thread being
  // flushed, in which case the entry is dropped without a handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_outValid  <= 1'b0;
      r_outAddr   <= '0;
      r_outThread <= 1'b0;
      r_rr        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_ovfSet) r_ovf <= 1'b1;
      if (w_loadSlot) begin
        if (w_avail != 2'b00) begin
          r_outValid  <= 1'b1;
          r_outAddr   <= w_head;
          r_outThread <= w_pick;
          r_rr        <= w_pick;
        end else begin
          r_outValid  <= 1'b0;
        end
      end else if (w_flush[r_outThread]) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign o_free[0]    = (r_count[0] != CW'(DEPTH));
  assign o_free[1]    = (r_count[1] != CW'(DEPTH));
  assign o_out_valid  = r_outValid;
  assign o_out_addr   = r_outAddr;
  assign o_out_thread = r_outThread;
  assign o_ovf        = r_ovf;

endmodule
